tube_host_initiator: RTL and testbench

Host-side bus initiator for the Tube ULA: converts single-byte commands from an on-chip client (test sequencer or soft host) into 6502-style phi2 bus cycles on the Tube host port. Each FIFO access first polls the matching status register: bit 6 (not full) before writes, bit 7 (data available) before reads. The data cycle is issued only when the relevant bit is set, and the block gives up after a bounded number of polls. It sits between the client and the Tube host pins (h_addr, h_cs_b, h_rdnw, h_phi2, h_data) and generates h_phi2 itself.

---
 rtl/tube_host_initiator.sv | 262 ++++++++++++++++++++++++++
 tb/tb_tube_host_initiator.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tube_host_initiator.sv
// Tube host-port bus initiator: turns single client commands into 6502-style
// phi2 bus cycles, polling the FIFO status register before each data access.
module tube_host_initiator #(
  parameter int HALF_PERIOD = 2,
  parameter int POLL_LIMIT  = 255
) (
  input  logic       clk,
  input  logic       h_rst_b,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [1:0] cmd_reg,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_err,
  output logic [2:0] h_addr,
  output logic       h_cs_b,
  output logic       h_rdnw,
  output logic       h_phi2,
  output logic [7:0] h_data_out,
  output logic       h_data_oe,
  input  logic [7:0] h_data_in,
  input  logic       h_irq_b,
  output logic       irq_pending
);

  localparam int PW = $clog2(2 * HALF_PERIOD);
  localparam logic [PW-1:0] POS_LAST    = PW'(2 * HALF_PERIOD - 1);
  localparam logic [PW-1:0] POS_LOW_END = PW'(HALF_PERIOD - 1);
  localparam logic [7:0]    POLL_MAX    = 8'(POLL_LIMIT);

  localparam logic [1:0] OP_FRD = 2'b00;
  localparam logic [1:0] OP_FWR = 2'b01;
  localparam logic [1:0] OP_CTL = 2'b10;
  localparam logic [1:0] OP_STS = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_POLL = 3'd2,
    S_XFER = 3'd3,
    S_RESP = 3'd4
  } state_t;

  typedef struct packed {
    state_t     st;
    logic [2:0] addr;
    logic       rdnw;
  } slot_t;

  // First bus cycle of a command: FIFO ops start by polling status.
  function automatic slot_t first_slot(input logic [1:0] op, input logic [1:0] rg);
    slot_t s;
    case (op)
      OP_FRD, OP_FWR: s = '{st: S_POLL, addr: {rg, 1'b0}, rdnw: 1'b1};
      OP_CTL:         s = '{st: S_XFER, addr: 3'd0, rdnw: 1'b0};
      OP_STS:         s = '{st: S_XFER, addr: {rg, 1'b0}, rdnw: 1'b1};
      default:        s = '{st: S_IDLE, addr: 3'd0, rdnw: 1'b1};
    endcase
    return s;
  endfunction

  function automatic logic fifo_ready(input logic [1:0] op, input logic [7:0] status);
    return (op == OP_FRD) ? status[7] : status[6];
  endfunction

  state_t       state_q, state_d;
  logic [PW-1:0] pos_q, pos_d;
  logic         phi2_q, phi2_d;
  logic [1:0]   op_q, op_d;
  logic [1:0]   reg_q, reg_d;
  logic [7:0]   wdata_q, wdata_d;
  logic [7:0]   poll_cnt_q, poll_cnt_d;
  logic         cmd_ready_q, cmd_ready_d;
  logic         rsp_valid_q, rsp_valid_d;
  logic [7:0]   rsp_data_q, rsp_data_d;
  logic         rsp_err_q, rsp_err_d;
  logic [2:0]   addr_q, addr_d;
  logic         cs_b_q, cs_b_d;
  logic         rdnw_q, rdnw_d;
  logic [7:0]   dout_q, dout_d;
  logic         doe_q, doe_d;
  logic         irq_s1_q, irq_s2_q;

  logic         slot_end;
  logic         accept;
  logic [7:0]   cnt_inc;
  slot_t        nxt;

  assign slot_end = (pos_q == POS_LAST);
  assign accept   = cmd_valid && cmd_ready_q;
  assign cnt_inc  = (poll_cnt_q == 8'hFF) ? 8'hFF : poll_cnt_q + 8'd1;

  // Next-state, phase and bus-pin decode
  always_comb begin
    pos_d      = slot_end ? '0 : pos_q + PW'(1);
    phi2_d     = (pos_d > POS_LOW_END);
    state_d    = state_q;
    op_d       = op_q;
    reg_d      = reg_q;
    wdata_d    = wdata_q;
    poll_cnt_d = poll_cnt_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    addr_d     = addr_q;
    cs_b_d     = cs_b_q;
    rdnw_d     = rdnw_q;
    dout_d     = dout_q;
    doe_d      = doe_q;
    nxt        = first_slot(op_q, reg_q);

    // Bus goes idle at every slot boundary unless a new cycle is launched below;
    // write data is driven only while phi2 is high.
    if (slot_end) begin
      cs_b_d = 1'b1;
      rdnw_d = 1'b1;
      doe_d  = 1'b0;
    end else if ((pos_q == POS_LOW_END) && (state_q == S_XFER) && !rdnw_q) begin
      doe_d  = 1'b1;
      dout_d = wdata_q;
    end else begin
      doe_d  = doe_q;
    end

    case (state_q)
      S_IDLE, S_RESP: begin
        if (accept) begin
          op_d       = cmd_op;
          reg_d      = cmd_reg;
          wdata_d    = cmd_wdata;
          poll_cnt_d = 8'd0;
          nxt        = first_slot(cmd_op, cmd_reg);
          if (slot_end) begin
            state_d = nxt.st;
            addr_d  = nxt.addr;
            rdnw_d  = nxt.rdnw;
            cs_b_d  = 1'b0;
          end else begin
            state_d = S_WAIT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (slot_end) begin
          state_d = nxt.st;
          addr_d  = nxt.addr;
          rdnw_d  = nxt.rdnw;
          cs_b_d  = 1'b0;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_POLL: begin
        // EVAL: status byte is tested as it is sampled, so the next slot follows directly
        if (slot_end) begin
          if (fifo_ready(op_q, h_data_in)) begin
            state_d = S_XFER;
            addr_d  = {reg_q, 1'b1};
            rdnw_d  = (op_q == OP_FRD);
            cs_b_d  = 1'b0;
          end else if (cnt_inc == POLL_MAX) begin
            poll_cnt_d = cnt_inc;
            state_d    = S_RESP;
            rsp_data_d = h_data_in;
            rsp_err_d  = 1'b1;
          end else begin
            poll_cnt_d = cnt_inc;
            state_d    = S_POLL;
            addr_d     = {reg_q, 1'b0};
            rdnw_d     = 1'b1;
            cs_b_d     = 1'b0;
          end
        end else begin
          state_d = S_POLL;
        end
      end
      S_XFER: begin
        if (slot_end) begin
          state_d   = S_RESP;
          rsp_err_d = 1'b0;
          case (op_q)
            OP_FRD, OP_STS: rsp_data_d = h_data_in;
            OP_FWR:         rsp_data_d = wdata_q;
            default:        rsp_data_d = 8'h00;
          endcase
        end else begin
          state_d = S_XFER;
        end
      end
      default: state_d = S_IDLE;
    endcase

    rsp_valid_d = (state_d == S_RESP);
    cmd_ready_d = (state_d == S_IDLE) || (state_d == S_RESP);
  end

  // Control, phase and bus-pin registers
  always_ff @(posedge clk or negedge h_rst_b) begin
    if (!h_rst_b) begin
      state_q     <= S_IDLE;
      pos_q       <= '0;
      phi2_q      <= 1'b0;
      op_q        <= 2'b00;
      reg_q       <= 2'b00;
      wdata_q     <= 8'h00;
      poll_cnt_q  <= 8'h00;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
      rsp_err_q   <= 1'b0;
      addr_q      <= 3'd0;
      cs_b_q      <= 1'b1;
      rdnw_q      <= 1'b1;
      dout_q      <= 8'h00;
      doe_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      phi2_q      <= phi2_d;
      op_q        <= op_d;
      reg_q       <= reg_d;
      wdata_q     <= wdata_d;
      poll_cnt_q  <= poll_cnt_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      addr_q      <= addr_d;
      cs_b_q      <= cs_b_d;
      rdnw_q      <= rdnw_d;
      dout_q      <= dout_d;
      doe_q       <= doe_d;
    end
  end

  // Two-flop synchroniser for the open-drain host interrupt
  always_ff @(posedge clk or negedge h_rst_b) begin
    if (!h_rst_b) begin
      irq_s1_q <= 1'b0;
      irq_s2_q <= 1'b0;
    end else begin
      irq_s1_q <= ~h_irq_b;
      irq_s2_q <= irq_s1_q;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_err     = rsp_err_q;
  assign h_addr      = addr_q;
  assign h_cs_b      = cs_b_q;
  assign h_rdnw      = rdnw_q;
  assign h_phi2      = phi2_q;
  assign h_data_out  = dout_q;
  assign h_data_oe   = doe_q;
  assign irq_pending = irq_s2_q;

endmodule

// File: tb/tb_tube_host_initiator.sv
// Bench for tube_host_initiator: a scripted Tube register model answers bus reads,
// a monitor records bus cycles, and a command-level reference predicts them.
module tb_tube_host_initiator;
  localparam int HP = 2;
  localparam int PL = 4;

  logic       clk = 1'b0;
  logic       h_rst_b = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [1:0] cmd_reg = 2'b00;
  logic [7:0] cmd_wdata = 8'h00;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic [2:0] h_addr;
  logic       h_cs_b;
  logic       h_rdnw;
  logic       h_phi2;
  logic [7:0] h_data_out;
  logic       h_data_oe;
  logic [7:0] h_data_in = 8'h00;
  logic       h_irq_b = 1'b1;
  logic       irq_pending;

  tube_host_initiator #(.HALF_PERIOD(HP), .POLL_LIMIT(PL)) dut (
    .clk(clk), .h_rst_b(h_rst_b),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .h_addr(h_addr), .h_cs_b(h_cs_b), .h_rdnw(h_rdnw), .h_phi2(h_phi2),
    .h_data_out(h_data_out), .h_data_oe(h_data_oe), .h_data_in(h_data_in),
    .h_irq_b(h_irq_b), .irq_pending(irq_pending)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Tube register model script
  logic [7:0] stat_seq[$];
  logic [7:0] rd_byte = 8'h00;
  int         stat_idx = 0;

  function automatic logic [7:0] stat_at(input int i);
    int k;
    k = (i < 0) ? 0 : i;
    if (stat_seq.size() == 0) return 8'h00;
    if (k >= stat_seq.size()) return stat_seq[stat_seq.size() - 1];
    return stat_seq[k];
  endfunction

  // Observed bus cycles and responses
  int ob_addr[$], ob_rd[$], ob_wd[$], ob_slot[$], ob_len[$];
  int ob_first = 0, ob_last = 0, shape_err = 0;
  int rsp_cyc[$], rsp_d[$], rsp_e[$], rsp_rdy[$];

  function automatic int now_cyc();
    return int'($time / 10);
  endfunction

  // Monitor + bus-side model, all on the falling clock edge
  initial begin
    logic prev_phi2 = 1'b0;
    logic prev_cs_b = 1'b1;
    int   slot = 0;
    int   c;
    int   last;
    forever begin
      @(negedge clk);
      c = now_cyc();
      if (prev_phi2 && !h_phi2) slot++;
      if (!h_cs_b) begin
        if (prev_cs_b || (prev_phi2 && !h_phi2)) begin
          ob_addr.push_back(int'(h_addr));
          ob_rd.push_back(int'(h_rdnw));
          ob_wd.push_back(-1);
          ob_slot.push_back(slot);
          ob_len.push_back(0);
          if (ob_addr.size() == 1) ob_first = c;
          if (h_rdnw && !h_addr[0]) stat_idx++;
        end
        last = ob_addr.size() - 1;
        ob_len[last] = ob_len[last] + 1;
        if (int'(h_addr) != ob_addr[last] || int'(h_rdnw) != ob_rd[last]) shape_err++;
        if (h_data_oe) begin
          if (!h_phi2 || h_rdnw) shape_err++;
          ob_wd[last] = int'(h_data_out);
        end else if (h_phi2 && !h_rdnw) begin
          shape_err++;
        end
        ob_last = c;
      end else begin
        if (h_data_oe || !h_rdnw) shape_err++;
      end
      h_data_in = h_addr[0] ? rd_byte : stat_at(stat_idx - 1);
      if (rsp_valid) begin
        rsp_cyc.push_back(c);
        rsp_d.push_back(int'(rsp_data));
        rsp_e.push_back(int'(rsp_err));
        rsp_rdy.push_back(int'(cmd_ready));
      end
      prev_phi2 = h_phi2;
      prev_cs_b = h_cs_b;
    end
  end

  task automatic clear_obs();
    ob_addr.delete(); ob_rd.delete(); ob_wd.delete(); ob_slot.delete(); ob_len.delete();
    rsp_cyc.delete(); rsp_d.delete(); rsp_e.delete(); rsp_rdy.delete();
    stat_idx = 0;
    shape_err = 0;
  endtask

  task automatic run_cmd(input string tag, input logic [1:0] op, input logic [1:0] rg,
                         input logic [7:0] wd);
    int e_addr[$], e_rd[$], e_wd[$];
    int e_data, e_err, acc, waited, bitn, d;
    logic [7:0] s;
    e_data = 0;
    e_err  = 0;
    bitn   = (op == 2'b00) ? 7 : 6;
    // Reference: expected bus cycles and response from the command rules
    case (op)
      2'b10: begin
        e_addr.push_back(0); e_rd.push_back(0); e_wd.push_back(int'(wd));
      end
      2'b11: begin
        e_addr.push_back(2 * int'(rg)); e_rd.push_back(1); e_wd.push_back(-1);
        e_data = int'(stat_at(0));
      end
      default: begin
        for (int i = 0; i < PL; i++) begin
          s = stat_at(i);
          e_addr.push_back(2 * int'(rg)); e_rd.push_back(1); e_wd.push_back(-1);
          if (s[bitn]) begin
            e_addr.push_back(2 * int'(rg) + 1);
            e_rd.push_back((op == 2'b00) ? 1 : 0);
            e_wd.push_back((op == 2'b00) ? -1 : int'(wd));
            e_data = (op == 2'b00) ? int'(rd_byte) : int'(wd);
            break;
          end
          if (i == PL - 1) begin
            e_data = int'(s);
            e_err  = 1;
          end
        end
      end
    endcase

    clear_obs();
    @(negedge clk);
    cmd_op = op; cmd_reg = rg; cmd_wdata = wd; cmd_valid = 1'b1;
    waited = 0;
    while (!cmd_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check_eq({tag, " accept"}, int'(cmd_ready), 1);
    acc = now_cyc();
    @(negedge clk);
    // Requests while busy must be ignored
    cmd_op = 2'($urandom); cmd_reg = 2'($urandom); cmd_wdata = 8'($urandom);
    @(negedge clk);
    cmd_valid = 1'b0;
    waited = 0;
    while (rsp_cyc.size() == 0 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    repeat (3) @(negedge clk);

    check_eq({tag, " ncyc"}, ob_addr.size(), e_addr.size());
    for (int i = 0; i < e_addr.size() && i < ob_addr.size(); i++) begin
      check_eq({tag, " addr"}, ob_addr[i], e_addr[i]);
      check_eq({tag, " rdnw"}, ob_rd[i], e_rd[i]);
      if (e_rd[i] == 0) check_eq({tag, " wdata"}, ob_wd[i], e_wd[i]);
      check_eq({tag, " cs_len"}, ob_len[i], 2 * HP);
      check_eq({tag, " slot_seq"}, ob_slot[i] - ob_slot[0], i);
    end
    if (ob_addr.size() > 0) begin
      d = ob_first - acc;
      check_eq({tag, " wait_lat"}, int'(d >= 1 && d <= 2 * HP), 1);
    end
    check_eq({tag, " nrsp"}, rsp_cyc.size(), 1);
    if (rsp_cyc.size() > 0) begin
      check_eq({tag, " rsp_data"}, rsp_d[0], e_data);
      check_eq({tag, " rsp_err"}, rsp_e[0], e_err);
      check_eq({tag, " rsp_ready"}, rsp_rdy[0], 1);
      check_eq({tag, " rsp_lat"}, rsp_cyc[0], ob_last + 1);
    end
    check_eq({tag, " bus_shape"}, shape_err, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] op, rg;
    logic [7:0] wd, b;
    int k, bitn, waited;

    repeat (3) @(negedge clk);
    check_eq("rst cmd_ready", int'(cmd_ready), 0);
    check_eq("rst rsp_valid", int'(rsp_valid), 0);
    check_eq("rst rsp_data", int'(rsp_data), 0);
    check_eq("rst rsp_err", int'(rsp_err), 0);
    check_eq("rst h_phi2", int'(h_phi2), 0);
    check_eq("rst h_cs_b", int'(h_cs_b), 1);
    check_eq("rst h_rdnw", int'(h_rdnw), 1);
    check_eq("rst h_addr", int'(h_addr), 0);
    check_eq("rst h_data_oe", int'(h_data_oe), 0);
    check_eq("rst h_data_out", int'(h_data_out), 0);
    check_eq("rst irq_pending", int'(irq_pending), 0);
    h_rst_b = 1'b1;
    #1;
    check_eq("rel ready_before_clk", int'(cmd_ready), 0);
    @(negedge clk);
    check_eq("rel ready_first_clk", int'(cmd_ready), 1);

    stat_seq = '{8'h3F};
    run_cmd("t1_status", 2'b11, 2'd0, 8'h00);
    stat_seq = '{8'h40};
    run_cmd("t2_fwrite", 2'b01, 2'd0, 8'hA5);
    stat_seq = '{8'h00, 8'h00, 8'h00, 8'h80};
    rd_byte  = 8'h5C;
    run_cmd("t3_fread", 2'b00, 2'd3, 8'h00);
    stat_seq = '{8'h00};
    run_cmd("t4_timeout", 2'b00, 2'd1, 8'h00);
    stat_seq = '{8'hFF};
    run_cmd("t5_ctrl", 2'b10, 2'd2, 8'h92);

    @(negedge clk);
    h_irq_b = 1'b0;
    @(negedge clk);
    check_eq("irq after1", int'(irq_pending), 0);
    @(negedge clk);
    check_eq("irq after2", int'(irq_pending), 1);
    h_irq_b = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("irq release", int'(irq_pending), 0);

    for (int n = 0; n < 30; n++) begin
      op   = 2'($urandom);
      rg   = 2'($urandom);
      wd   = 8'($urandom);
      rd_byte = 8'($urandom);
      k    = $urandom_range(0, 5);
      bitn = (op == 2'b00) ? 7 : 6;
      stat_seq.delete();
      for (int i = 0; i < k; i++) begin
        b = 8'($urandom);
        b[bitn] = 1'b0;
        stat_seq.push_back(b);
      end
      b = 8'($urandom);
      b[bitn] = 1'b1;
      stat_seq.push_back(b);
      run_cmd("rand", op, rg, wd);
    end

    // Reset in the middle of a write data slot
    clear_obs();
    stat_seq = '{8'h40};
    @(negedge clk);
    cmd_op = 2'b01; cmd_reg = 2'd2; cmd_wdata = 8'h3C; cmd_valid = 1'b1;
    waited = 0;
    while (!cmd_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    waited = 0;
    while (!h_data_oe && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    check_eq("rstx reached_xfer", int'(h_data_oe), 1);
    h_rst_b = 1'b0;
    #1;
    check_eq("rstx h_cs_b", int'(h_cs_b), 1);
    check_eq("rstx h_data_oe", int'(h_data_oe), 0);
    check_eq("rstx cmd_ready", int'(cmd_ready), 0);
    check_eq("rstx rsp_valid", int'(rsp_valid), 0);
    repeat (3) @(negedge clk);
    h_rst_b = 1'b1;
    #1;
    check_eq("rstx ready_before_clk", int'(cmd_ready), 0);
    @(negedge clk);
    check_eq("rstx ready_first_clk", int'(cmd_ready), 1);
    repeat (6) @(negedge clk);
    check_eq("rstx no_rsp", rsp_cyc.size(), 0);

    stat_seq = '{8'h80};
    rd_byte  = 8'hC3;
    run_cmd("after_rst", 2'b00, 2'd2, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
